// File: rtl/proxy_pool_arbiter_pkg.sv
// proxy_pool_arbiter_pkg: proxy state encoding, index-width helper and counter width for the proxy pool arbiter
package proxy_pool_arbiter_pkg;
  typedef enum logic [1:0] {FREE = 2'd0, LOAD = 2'd1, COMPUTE = 2'd2} proxy_state_t;
  localparam int DENIED_W = 16;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/proxy_pool_arbiter_rr_arbiter.sv
// rr_arbiter: pointer-rotated priority select (req in, one-hot gnt, idx, valid out); first req at or after ptr wins
module rr_arbiter
  import proxy_pool_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % N]) idx = IW'((int'(ptr) + i) % N);
  end
  assign valid = |req;
  assign gnt = valid ? N'(1) << idx : '0;
endmodule

// File: rtl/proxy_pool_arbiter.sv
// proxy_pool_arbiter: round-robin sharing of spare proxy PEs among column recompute controllers
// clk/rst sync active-high; col_req/col_release per column; clear_alloc drops all allocations;
// col_grant/col_proxy_idx per column; proxy_owner/proxy_busy/load_proxy/proxy_matmul per proxy;
// pool_full when all proxies busy; denied_cnt saturating count of blocked cycles
module proxy_pool_arbiter
  import proxy_pool_arbiter_pkg::*;
#(
  parameter int COLS        = 4,
  parameter int NUM_PROXY   = 2,
  parameter int LOAD_CYCLES = 2,
  parameter int CIDX_W      = idx_w(COLS),
  parameter int PIDX_W      = idx_w(NUM_PROXY)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [COLS-1:0]               col_req,
  input  logic [COLS-1:0]               col_release,
  input  logic                          clear_alloc,
  output logic [COLS-1:0]               col_grant,
  output logic [COLS*PIDX_W-1:0]        col_proxy_idx,
  output logic [NUM_PROXY*CIDX_W-1:0]   proxy_owner,
  output logic [NUM_PROXY-1:0]          proxy_busy,
  output logic [NUM_PROXY-1:0]          load_proxy,
  output logic [NUM_PROXY-1:0]          proxy_matmul,
  output logic                          pool_full,
  output logic [DENIED_W-1:0]           denied_cnt
);
  localparam int CNT_W = idx_w(LOAD_CYCLES);
  logic [CIDX_W-1:0]    rr_ptr, win_idx;
  logic [COLS-1:0]      pending, win_gnt, freed_cols;
  logic                 win_valid, alloc;
  logic [PIDX_W-1:0]    free_idx;
  logic [NUM_PROXY-1:0] freeing;
  assign pending   = col_req & ~col_grant;
  assign pool_full = &proxy_busy;
  assign alloc     = win_valid && !pool_full && !clear_alloc;
  rr_arbiter #(.N(COLS), .IW(CIDX_W)) u_rr (
    .req   (pending),
    .ptr   (rr_ptr),
    .gnt   (win_gnt),
    .idx   (win_idx),
    .valid (win_valid)
  );
  always_comb begin
    free_idx = '0;
    for (int i = NUM_PROXY - 1; i >= 0; i--)
      if (!proxy_busy[i]) free_idx = PIDX_W'(i);
  end
  // a column's grant drops on the same edge its proxy returns to FREE
  always_comb begin
    freed_cols = '0;
    for (int i = 0; i < NUM_PROXY; i++)
      if (freeing[i]) freed_cols[proxy_owner[i*CIDX_W +: CIDX_W]] = 1'b1;
  end
  for (genvar p = 0; p < NUM_PROXY; p++) begin : g_proxy
    proxy_state_t      st, st_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [CIDX_W-1:0] own, own_n;
    logic              relp, relp_n, rel_hit, last;
    assign rel_hit = col_release[own] && st != FREE;
    assign last    = cnt == CNT_W'(LOAD_CYCLES - 1);
    // a release seen during LOAD is held in relp and honoured when LOAD ends
    always_comb begin
      st_n   = st;
      cnt_n  = cnt;
      own_n  = own;
      relp_n = relp;
      case (st)
        FREE: if (alloc && free_idx == PIDX_W'(p)) begin
          st_n   = LOAD;
          cnt_n  = '0;
          own_n  = win_idx;
          relp_n = 1'b0;
        end
        LOAD: begin
          relp_n = relp | rel_hit;
          cnt_n  = last ? '0 : cnt + 1'b1;
          st_n   = last ? (relp_n ? FREE : COMPUTE) : LOAD;
          own_n  = (last && relp_n) ? '0 : own;
        end
        COMPUTE: if (rel_hit) begin
          st_n  = FREE;
          own_n = '0;
        end
        default: st_n = FREE;
      endcase
      if (clear_alloc) begin
        st_n   = FREE;
        cnt_n  = '0;
        own_n  = '0;
        relp_n = 1'b0;
      end
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        st   <= FREE;
        cnt  <= '0;
        own  <= '0;
        relp <= 1'b0;
      end else begin
        st   <= st_n;
        cnt  <= cnt_n;
        own  <= own_n;
        relp <= relp_n;
      end
    end
    assign freeing[p]                        = st != FREE && st_n == FREE;
    assign proxy_busy[p]                     = st != FREE;
    assign load_proxy[p]                     = st == LOAD;
    assign proxy_matmul[p]                   = st == COMPUTE;
    assign proxy_owner[p*CIDX_W +: CIDX_W]   = own;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      col_grant     <= '0;
      col_proxy_idx <= '0;
      rr_ptr        <= '0;
      denied_cnt    <= '0;
    end else begin
      if (pool_full && |pending && !clear_alloc && denied_cnt != '1) denied_cnt <= denied_cnt + 1'b1;
      col_grant <= clear_alloc ? '0 : (col_grant & ~freed_cols) | (alloc ? win_gnt : '0);
      if (clear_alloc) rr_ptr <= '0;
      else if (alloc) rr_ptr <= (win_idx == CIDX_W'(COLS - 1)) ? '0 : win_idx + 1'b1;
      if (alloc) col_proxy_idx[win_idx*PIDX_W +: PIDX_W] <= free_idx;
    end
  end
endmodule

// File: tb/tb_proxy_pool_arbiter.sv
// tb_proxy_pool_arbiter: directed scenarios plus randomized run against a behavioural pool model
module tb_proxy_pool_arbiter;
  localparam int C = 4, NP = 2, LC = 2, CW = 2, PW = 1;
  logic clk = 0, rst = 1, clear_alloc = 0;
  logic [C-1:0] col_req = '0, col_release = '0, col_grant;
  logic [C*PW-1:0] col_proxy_idx;
  logic [NP*CW-1:0] proxy_owner;
  logic [NP-1:0] proxy_busy, load_proxy, proxy_matmul;
  logic pool_full;
  logic [15:0] denied_cnt;
  int passed = 0, total = 0;
  int m_st[NP], m_own[NP], m_left[NP], m_pi[C], m_rr, m_den;
  bit m_relf[NP], m_g[C];

  proxy_pool_arbiter #(.COLS(C), .NUM_PROXY(NP), .LOAD_CYCLES(LC)) dut (
    .clk(clk), .rst(rst), .col_req(col_req), .col_release(col_release), .clear_alloc(clear_alloc),
    .col_grant(col_grant), .col_proxy_idx(col_proxy_idx), .proxy_owner(proxy_owner),
    .proxy_busy(proxy_busy), .load_proxy(load_proxy), .proxy_matmul(proxy_matmul),
    .pool_full(pool_full), .denied_cnt(denied_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin m_st[p] = 0; m_own[p] = 0; m_left[p] = 0; m_relf[p] = 0; end
    for (int c = 0; c < C; c++) begin m_g[c] = 0; m_pi[c] = 0; end
    m_rr = 0; m_den = 0;
  endtask

  // state codes: 0 free, 1 loading, 2 computing
  task automatic model_step(input logic [C-1:0] req, input logic [C-1:0] rel, input bit clr);
    logic [C-1:0] pend;
    bit full;
    int w, fp;
    full = 1;
    for (int p = 0; p < NP; p++) if (m_st[p] == 0) full = 0;
    for (int c = 0; c < C; c++) pend[c] = req[c] && !m_g[c];
    if (full && pend != 0 && !clr && m_den < 65535) m_den++;
    if (clr) begin
      for (int p = 0; p < NP; p++) begin m_st[p] = 0; m_own[p] = 0; end
      for (int c = 0; c < C; c++) m_g[c] = 0;
      m_rr = 0;
      return;
    end
    w = -1; fp = -1;
    if (!full) for (int k = 0; k < C; k++) if (w < 0 && pend[(m_rr + k) % C]) w = (m_rr + k) % C;
    for (int p = 0; p < NP; p++) if (fp < 0 && m_st[p] == 0) fp = p;
    for (int p = 0; p < NP; p++) begin
      if (m_st[p] == 1) begin
        if (rel[m_own[p]]) m_relf[p] = 1;
        m_left[p]--;
        if (m_left[p] == 0) begin
          if (m_relf[p]) begin m_st[p] = 0; m_g[m_own[p]] = 0; m_own[p] = 0; end
          else m_st[p] = 2;
        end
      end else if (m_st[p] == 2 && rel[m_own[p]]) begin
        m_st[p] = 0; m_g[m_own[p]] = 0; m_own[p] = 0;
      end
    end
    if (w >= 0) begin
      m_st[fp] = 1; m_left[fp] = LC; m_own[fp] = w; m_relf[fp] = 0;
      m_g[w] = 1; m_pi[w] = fp; m_rr = (w + 1) % C;
    end
  endtask

  task automatic cyc(input logic [C-1:0] req, input logic [C-1:0] rel = '0, input bit clr = 0, input bit r = 0);
    col_req = req; col_release = rel; clear_alloc = clr; rst = r;
    if (r) model_reset(); else model_step(req, rel, clr);
    @(posedge clk); #1;
  endtask

  function automatic logic [C-1:0] e_grant();
    for (int c = 0; c < C; c++) e_grant[c] = m_g[c];
  endfunction
  function automatic logic [NP-1:0] e_state(input int s);
    for (int p = 0; p < NP; p++) e_state[p] = (s < 0) ? (m_st[p] != 0) : (m_st[p] == s);
  endfunction
  function automatic logic [NP*CW-1:0] e_owner();
    for (int p = 0; p < NP; p++) e_owner[p*CW +: CW] = CW'(m_own[p]);
  endfunction

  task automatic test_reset();
    cyc('0, '0, 0, 1); cyc('0, '0, 0, 1);
    total++; if (col_grant !== '0) $display("FAIL reset_grant got %b want 0", col_grant); else passed++;
    total++; if (col_proxy_idx !== '0) $display("FAIL reset_pidx got %b want 0", col_proxy_idx); else passed++;
    total++; if (proxy_owner !== '0) $display("FAIL reset_owner got %b want 0", proxy_owner); else passed++;
    total++; if ({proxy_busy, load_proxy, proxy_matmul, pool_full} !== '0) $display("FAIL reset_state got %b want 0", {proxy_busy, load_proxy, proxy_matmul, pool_full}); else passed++;
    total++; if (denied_cnt !== '0) $display("FAIL reset_denied got %0d want 0", denied_cnt); else passed++;
  endtask

  task automatic test_single();
    cyc(4'b0100);
    total++; if (col_grant !== 4'b0100) $display("FAIL single_grant got %b want 0100", col_grant); else passed++;
    total++; if (proxy_owner !== 4'b0010) $display("FAIL single_owner got %b want 0010", proxy_owner); else passed++;
    total++; if (load_proxy !== 2'b01) $display("FAIL single_load1 got %b want 01", load_proxy); else passed++;
    cyc(4'b0100);
    total++; if (load_proxy !== 2'b01 || proxy_matmul !== 2'b00) $display("FAIL single_load2 got %b/%b want 01/00", load_proxy, proxy_matmul); else passed++;
    cyc(4'b0100);
    total++; if (proxy_matmul !== 2'b01 || load_proxy !== 2'b00) $display("FAIL single_matmul got %b/%b want 01/00", proxy_matmul, load_proxy); else passed++;
    cyc(4'b0000, 4'b0100);
    total++; if (proxy_busy !== 2'b00 || col_grant !== 4'b0000) $display("FAIL single_release got %b/%b want 00/0000", proxy_busy, col_grant); else passed++;
  endtask

  task automatic test_round_robin();
    cyc('0, '0, 0, 1);
    cyc(4'b1111);
    total++; if (col_grant !== 4'b0001 || proxy_owner[1:0] !== 2'd0) $display("FAIL rr_first got %b want 0001", col_grant); else passed++;
    cyc(4'b1111);
    total++; if (col_grant !== 4'b0011 || proxy_owner !== 4'b0100) $display("FAIL rr_second got %b owner %b want 0011 owner 0100", col_grant, proxy_owner); else passed++;
    total++; if (pool_full !== 1'b1) $display("FAIL rr_full got %b want 1", pool_full); else passed++;
    cyc(4'b1111);
    cyc(4'b1111, 4'b0001);
    total++; if (col_grant !== 4'b0010 || proxy_busy !== 2'b10) $display("FAIL rr_release got %b/%b want 0010/10", col_grant, proxy_busy); else passed++;
    cyc(4'b1111);
    total++; if (col_grant !== 4'b0110 || proxy_owner !== 4'b0110) $display("FAIL rr_regrant got %b owner %b want 0110 owner 0110", col_grant, proxy_owner); else passed++;
  endtask

  task automatic test_contention();
    cyc('0, '0, 0, 1);
    cyc(4'b0011); cyc(4'b0011);
    for (int i = 0; i < 5; i++) cyc(4'b1011);
    total++; if (denied_cnt !== 16'd5) $display("FAIL cont_denied5 got %0d want 5", denied_cnt); else passed++;
    cyc(4'b1010, 4'b0001);
    total++; if (col_grant !== 4'b0010 || denied_cnt !== 16'd6) $display("FAIL cont_release got %b/%0d want 0010/6", col_grant, denied_cnt); else passed++;
    cyc(4'b1010);
    total++; if (col_grant !== 4'b1010 || proxy_owner[1:0] !== 2'd3) $display("FAIL cont_grant3 got %b owner %b want 1010 owner 11", col_grant, proxy_owner); else passed++;
  endtask

  task automatic test_release_in_load();
    cyc('0, '0, 0, 1);
    cyc(4'b0001);
    cyc(4'b0000);
    total++; if (load_proxy !== 2'b01) $display("FAIL rload_load got %b want 01", load_proxy); else passed++;
    cyc(4'b0000, 4'b0001);
    total++; if (proxy_busy !== 2'b00 || proxy_matmul !== 2'b00 || col_grant !== 4'b0000) $display("FAIL rload_free got %b/%b/%b want 00/00/0000", proxy_busy, proxy_matmul, col_grant); else passed++;
    cyc(4'b0000);
    total++; if (proxy_matmul !== 2'b00) $display("FAIL rload_nomatmul got %b want 00", proxy_matmul); else passed++;
  endtask

  task automatic test_clear();
    cyc('0, '0, 0, 1);
    cyc(4'b0100); cyc(4'b0110); cyc(4'b0111);
    total++; if (denied_cnt !== 16'd1) $display("FAIL clr_predenied got %0d want 1", denied_cnt); else passed++;
    cyc(4'b1001, 4'b0100, 1);
    total++; if (col_grant !== 4'b0000 || proxy_busy !== 2'b00 || proxy_owner !== '0) $display("FAIL clr_state got %b/%b/%b want 0000/00/0000", col_grant, proxy_busy, proxy_owner); else passed++;
    total++; if (denied_cnt !== 16'd1) $display("FAIL clr_denied got %0d want 1", denied_cnt); else passed++;
    cyc(4'b1001);
    total++; if (col_grant !== 4'b0001) $display("FAIL clr_rrptr got %b want 0001", col_grant); else passed++;
  endtask

  task automatic test_spurious_rst();
    cyc('0, '0, 0, 1);
    cyc(4'b0001); cyc(4'b0000); cyc(4'b0000);
    cyc(4'b0000, 4'b0010);
    total++; if (col_grant !== 4'b0001 || proxy_matmul !== 2'b01 || proxy_owner !== '0 || proxy_busy !== 2'b01) $display("FAIL spur_release got %b/%b/%b/%b want 0001/01/0000/01", col_grant, proxy_matmul, proxy_owner, proxy_busy); else passed++;
    cyc(4'b0001, 4'b0000, 0, 1);
    total++; if ({col_grant, col_proxy_idx, proxy_owner, proxy_busy, load_proxy, proxy_matmul, pool_full, denied_cnt} !== '0) $display("FAIL spur_rst got nonzero %h want 0", {col_grant, col_proxy_idx, proxy_owner, proxy_busy, load_proxy, proxy_matmul, pool_full, denied_cnt}); else passed++;
  endtask

  task automatic test_random();
    logic [C-1:0] req, rel;
    cyc('0, '0, 0, 1);
    for (int n = 0; n < 400; n++) begin
      req = C'($urandom);
      rel = ($urandom_range(0, 3) == 0) ? C'($urandom) : C'($urandom) & e_grant();
      cyc(req, rel, $urandom_range(0, 39) == 0, $urandom_range(0, 149) == 0);
      total++; if (col_grant !== e_grant()) $display("FAIL rand_grant cyc %0d got %b want %b", n, col_grant, e_grant()); else passed++;
      total++; if (proxy_busy !== e_state(-1) || load_proxy !== e_state(1) || proxy_matmul !== e_state(2)) $display("FAIL rand_state cyc %0d got %b/%b/%b want %b/%b/%b", n, proxy_busy, load_proxy, proxy_matmul, e_state(-1), e_state(1), e_state(2)); else passed++;
      total++; if (proxy_owner !== e_owner()) $display("FAIL rand_owner cyc %0d got %b want %b", n, proxy_owner, e_owner()); else passed++;
      total++; if (pool_full !== &e_state(-1) || denied_cnt !== 16'(m_den)) $display("FAIL rand_full_denied cyc %0d got %b/%0d want %b/%0d", n, pool_full, denied_cnt, &e_state(-1), m_den); else passed++;
      for (int c = 0; c < C; c++) if (m_g[c]) begin
        total++; if (col_proxy_idx[c*PW +: PW] !== PW'(m_pi[c])) $display("FAIL rand_pidx cyc %0d col %0d got %0d want %0d", n, c, col_proxy_idx[c*PW +: PW], m_pi[c]); else passed++;
      end
      total++; if ($countones(col_grant) != $countones(proxy_busy)) $display("FAIL inv_popcount cyc %0d got %0d grants want %0d", n, $countones(col_grant), $countones(proxy_busy)); else passed++;
      for (int a = 0; a < NP; a++) for (int b = a + 1; b < NP; b++) if (proxy_busy[a] && proxy_busy[b]) begin
        total++; if (proxy_owner[a*CW +: CW] === proxy_owner[b*CW +: CW]) $display("FAIL inv_unique_owner cyc %0d got col %0d twice want distinct", n, proxy_owner[a*CW +: CW]); else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_contention();
    test_release_in_load();
    test_clear();
    test_spurious_rst();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
